// File: rtl/mem_sync_arbiter.sv
// Round-robin arbiter sharing one backing-store transfer channel among NBANKS row-cache
// sync FSMs: grant, command handshake, BEATS data beats, then a one-cycle sync pulse.
module mem_sync_arbiter #(
  parameter int NBANKS    = 4,
  parameter int CHWIDTH   = 6,
  parameter int ADDRWIDTH = 17,
  parameter int BEATS     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NBANKS-1:0]             req,
  input  logic [NBANKS-1:0]             wb,
  input  logic [NBANKS*CHWIDTH-1:0]     crow,
  input  logic [NBANKS*ADDRWIDTH-1:0]   row,
  output logic [NBANKS-1:0]             sync,
  output logic                          xfer_valid,
  input  logic                          xfer_ready,
  output logic                          xfer_wr,
  output logic [$clog2(NBANKS)-1:0]     xfer_bank,
  output logic [CHWIDTH-1:0]            xfer_crow,
  output logic [ADDRWIDTH-1:0]          xfer_row,
  input  logic                          xfer_beat,
  output logic                          busy
);

  localparam int BW = $clog2(NBANKS);
  localparam int CW = $clog2(BEATS + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, XFER, DONE} state_t;

  state_t                 state_q, state_d;
  logic [BW-1:0]          ptr_q, ptr_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NBANKS-1:0]      sync_q, sync_d;
  logic                   xfer_valid_q, xfer_valid_d;
  logic                   xfer_wr_q, xfer_wr_d;
  logic [BW-1:0]          xfer_bank_q, xfer_bank_d;
  logic [CHWIDTH-1:0]     xfer_crow_q, xfer_crow_d;
  logic [ADDRWIDTH-1:0]   xfer_row_q, xfer_row_d;
  logic                   busy_q, busy_d;

  logic                   grant_vld;
  logic [BW-1:0]          grant_idx;
  logic [BW-1:0]          cand;

  // Bank index base+offs with modulo-NBANKS wrap; offs is always below NBANKS.
  function automatic logic [BW-1:0] wrap_idx(input logic [BW-1:0] base, input int unsigned offs);
    int unsigned s;
    s = 32'(base) + offs;
    if (s >= NBANKS) s = s - NBANKS;
    return BW'(s);
  endfunction

  // NOTE: every variable written in always_comb gets a default first, so no path leaves it
  // unassigned and no latch is inferred; blocking (=) belongs here, non-blocking (<=) in always_ff.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NBANKS; k++) begin
      cand = wrap_idx(ptr_q, k);
      if (!grant_vld && req[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    sync_d       = '0;
    xfer_valid_d = xfer_valid_q;
    xfer_wr_d    = xfer_wr_q;
    xfer_bank_d  = xfer_bank_q;
    xfer_crow_d  = xfer_crow_q;
    xfer_row_d   = xfer_row_q;

    unique case (state_q)
      IDLE: begin
        if (grant_vld) begin
          state_d      = ISSUE;
          xfer_valid_d = 1'b1;
          xfer_bank_d  = grant_idx;
          xfer_wr_d    = wb[grant_idx];
          xfer_crow_d  = crow[grant_idx*CHWIDTH +: CHWIDTH];
          xfer_row_d   = row[grant_idx*ADDRWIDTH +: ADDRWIDTH];
          ptr_d        = wrap_idx(grant_idx, 1);
        end
      end
      ISSUE: begin
        if (xfer_ready) begin
          state_d      = XFER;
          xfer_valid_d = 1'b0;
          cnt_d        = '0;
        end
      end
      XFER: begin
        if (xfer_beat) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(BEATS - 1)) begin
            state_d             = DONE;
            sync_d[xfer_bank_q] = 1'b1;
          end
        end
      end
      DONE: begin
        // No arbitration here: the served bank needs this cycle to update its stall/op.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      sync_q       <= '0;
      xfer_valid_q <= 1'b0;
      xfer_wr_q    <= 1'b0;
      xfer_bank_q  <= '0;
      xfer_crow_q  <= '0;
      xfer_row_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      sync_q       <= sync_d;
      xfer_valid_q <= xfer_valid_d;
      xfer_wr_q    <= xfer_wr_d;
      xfer_bank_q  <= xfer_bank_d;
      xfer_crow_q  <= xfer_crow_d;
      xfer_row_q   <= xfer_row_d;
      busy_q       <= busy_d;
    end
  end

  assign sync       = sync_q;
  assign xfer_valid = xfer_valid_q;
  assign xfer_wr    = xfer_wr_q;
  assign xfer_bank  = xfer_bank_q;
  assign xfer_crow  = xfer_crow_q;
  assign xfer_row   = xfer_row_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mem_sync_arbiter.sv
// Self-checking bench for mem_sync_arbiter: transaction-level model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_mem_sync_arbiter;

  localparam int NB    = 4;
  localparam int CHW   = 6;
  localparam int AW    = 17;
  localparam int BEATS = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NB-1:0]     req = '0;
  logic [NB-1:0]     wb = '0;
  logic [NB*CHW-1:0] crow = '0;
  logic [NB*AW-1:0]  row = '0;
  logic [NB-1:0]     sync;
  logic              xfer_valid;
  logic              xfer_ready = 1'b0;
  logic              xfer_wr;
  logic [1:0]        xfer_bank;
  logic [CHW-1:0]    xfer_crow;
  logic [AW-1:0]     xfer_row;
  logic              xfer_beat = 1'b0;
  logic              busy;

  mem_sync_arbiter #(.NBANKS(NB), .CHWIDTH(CHW), .ADDRWIDTH(AW), .BEATS(BEATS)) dut (
    .clk(clk), .rst(rst), .req(req), .wb(wb), .crow(crow), .row(row), .sync(sync),
    .xfer_valid(xfer_valid), .xfer_ready(xfer_ready), .xfer_wr(xfer_wr),
    .xfer_bank(xfer_bank), .xfer_crow(xfer_crow), .xfer_row(xfer_row),
    .xfer_beat(xfer_beat), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one service at a time, round-robin pointer as an integer.
  int            m_ptr = 0;
  bit            m_serving = 0;
  bit            m_valid = 0;
  int            m_beats = 0;
  int            m_bank = 0;
  logic [NB-1:0] m_sync = '0;
  logic          m_busy = 1'b0;
  logic          m_wr = 1'b0;
  logic [CHW-1:0] m_crow = '0;
  logic [AW-1:0]  m_row = '0;
  bit            found;
  int            b;

  int grant_log[$];
  int sync_count = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_ptr = 0; m_serving = 0; m_valid = 0; m_beats = 0; m_bank = 0;
      m_sync = '0; m_wr = 1'b0; m_crow = '0; m_row = '0;
    end else if (m_sync != '0) begin
      m_sync = '0;
    end else if (!m_serving) begin
      found = 0;
      for (int k = 0; k < NB; k++) begin
        b = (m_ptr + k) % NB;
        if (!found && req[b]) begin
          found = 1;
          m_bank = b;
        end
      end
      if (found) begin
        m_serving = 1;
        m_valid   = 1;
        m_wr      = wb[m_bank];
        m_crow    = crow[m_bank*CHW +: CHW];
        m_row     = row[m_bank*AW +: AW];
        m_ptr     = (m_bank + 1) % NB;
      end
    end else if (m_valid) begin
      if (xfer_ready) begin
        m_valid = 0;
        m_beats = 0;
      end
    end else if (xfer_beat) begin
      m_beats++;
      if (m_beats == BEATS) begin
        m_sync    = NB'(1) << m_bank;
        m_serving = 0;
      end
    end
    m_busy = m_serving || (m_sync != '0);

    #1;
    check("model_sync", sync, m_sync);
    check("model_valid", xfer_valid, m_valid);
    check("model_busy", busy, m_busy);
    check("model_bank", xfer_bank, m_bank[1:0]);
    check("model_wr", xfer_wr, m_wr);
    check("model_crow", xfer_crow, m_crow);
    check("model_row", xfer_row, m_row);

    if (xfer_valid && !prev_valid) grant_log.push_back(int'(xfer_bank));
    prev_valid = xfer_valid;
    if (sync != '0) sync_count++;
  end

  task automatic wait_syncs(input int target);
    int n = 0;
    while (sync_count < target && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("wait_syncs", sync_count, target);
  endtask

  // Drives BEATS consecutive beats; sync must appear exactly after the last one.
  task automatic run_beats(input logic [NB-1:0] mask);
    for (int i = 0; i < BEATS; i++) begin
      xfer_beat = 1'b1;
      @(negedge clk);
      check("beat_sync", sync, (i == BEATS - 1) ? mask : '0);
    end
    xfer_beat = 1'b0;
    req = '0;
    @(negedge clk);
    check("sync_one_cycle", sync, 4'b0000);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    repeat (2) @(negedge clk);
    check("rst_valid", xfer_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_sync", sync, 4'b0000);
    rst = 1'b0;

    // Single write-back from bank 1.
    wb = 4'b0010;
    crow[1*CHW +: CHW] = 6'd5;
    row[1*AW +: AW] = 17'h1A2B;
    req = 4'b0010;
    xfer_ready = 1'b1;
    @(negedge clk);
    check("t1_valid", xfer_valid, 1'b1);
    check("t1_bank", xfer_bank, 2'd1);
    check("t1_wr", xfer_wr, 1'b1);
    check("t1_crow", xfer_crow, 6'd5);
    check("t1_row", xfer_row, 17'h1A2B);
    @(negedge clk);
    check("t1_valid_fall", xfer_valid, 1'b0);
    check("t1_busy", busy, 1'b1);
    run_beats(4'b0010);
    check("t1_idle", busy, 1'b0);

    // All banks requesting from reset: 0,1,2,3,0.
    do_reset();
    grant_log.delete();
    s0 = sync_count;
    req = 4'b1111;
    xfer_ready = 1'b1;
    xfer_beat = 1'b1;
    wait_syncs(s0 + 5);
    req = '0;
    xfer_beat = 1'b0;
    check("t2_ngrants", grant_log.size(), 5);
    if (grant_log.size() == 5) begin
      check("t2_g0", grant_log[0], 0);
      check("t2_g1", grant_log[1], 1);
      check("t2_g2", grant_log[2], 2);
      check("t2_g3", grant_log[3], 3);
      check("t2_g4", grant_log[4], 0);
    end
    repeat (2) @(negedge clk);

    // Pointer moved to 3 by serving bank 2; then 4'b1001 -> 3 before 0.
    grant_log.delete();
    s0 = sync_count;
    req = 4'b0100;
    xfer_beat = 1'b1;
    wait_syncs(s0 + 1);
    req = 4'b1001;
    wait_syncs(s0 + 3);
    req = '0;
    xfer_beat = 1'b0;
    check("t3_ngrants", grant_log.size(), 3);
    if (grant_log.size() == 3) begin
      check("t3_g0", grant_log[0], 2);
      check("t3_g1", grant_log[1], 3);
      check("t3_g2", grant_log[2], 0);
    end
    repeat (2) @(negedge clk);

    // Ready held low: command stable, beats during ISSUE ignored.
    wb[0] = 1'b0;
    crow[0*CHW +: CHW] = 6'd9;
    row[0*AW +: AW] = 17'h0ABCD;
    req = 4'b0001;
    xfer_ready = 1'b0;
    xfer_beat = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check("t4_valid", xfer_valid, 1'b1);
      check("t4_bank", xfer_bank, 2'd0);
      check("t4_wr", xfer_wr, 1'b0);
      check("t4_crow", xfer_crow, 6'd9);
      check("t4_row", xfer_row, 17'h0ABCD);
      row[0*AW +: AW] = AW'(i);
      wb[0] = 1'b1;
      @(negedge clk);
    end
    xfer_ready = 1'b1;
    xfer_beat = 1'b0;
    @(negedge clk);
    check("t4_valid_fall", xfer_valid, 1'b0);
    run_beats(4'b0001);

    // Bank 2 drops req and changes row mid-transfer; still served with latched row.
    wb[2] = 1'b1;
    crow[2*CHW +: CHW] = 6'd33;
    row[2*AW +: AW] = 17'h1F00F;
    req = 4'b0100;
    xfer_ready = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2 * BEATS; i++) begin
      xfer_beat = (i % 2 == 0);
      if (i == 8) begin
        req = '0;
        row[2*AW +: AW] = 17'h00001;
      end
      @(negedge clk);
      check("t5_sync", sync, (i == 2 * BEATS - 2) ? 4'b0100 : 4'b0000);
      check("t5_row", xfer_row, 17'h1F00F);
    end
    xfer_beat = 1'b0;

    // Reset after 8 beats aborts the transfer; pointer returns to 0.
    req = 4'b0010;
    repeat (2) @(negedge clk);
    xfer_beat = 1'b1;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_valid", xfer_valid, 1'b0);
    check("t6_busy", busy, 1'b0);
    check("t6_bank", xfer_bank, 2'd0);
    check("t6_row", xfer_row, 17'h0);
    check("t6_sync", sync, 4'b0000);
    rst = 1'b0;
    xfer_beat = 1'b0;
    req = '0;
    s0 = sync_count;
    repeat (20) @(negedge clk);
    check("t6_no_sync", sync_count, s0);
    req = 4'b0101;
    @(negedge clk);
    check("t6_ptr0_bank", xfer_bank, 2'd0);
    xfer_beat = 1'b1;
    wait_syncs(s0 + 1);
    req = '0;
    xfer_beat = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
